fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register for decode. Honours hazard-unit stalls, branch-resolution flushes and redirects. Optionally applies static backward-taken branch prediction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- imem_addr  out  32  byte address to instruction memory, equals pc_q
- imem_rdata  in  32  instruction word from memory, valid in the same cycle
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  replace IF/ID contents with bubble
- redirect_i  in  1  EX-stage branch/jump resolved to new PC
- redirect_pc_i  in  32  target PC for redirect
- ifid_instr  out  32  registered instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_pc_plus4  out  32  ifid_pc + 4
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pred_taken  out  1  fetch predicted this instruction taken
- fetch_count  out  32  number of instructions delivered valid into IF/ID

## Operation
- State: pc_q, IF/ID register {instr, pc, valid, pred_taken}, fetch_count.
- Next-PC selection, priority high to low: reset -> RESET_PC; redirect_i -> {redirect_pc_i[31:2],2'b00}; stall_i -> pc_q; prediction (if enabled) -> pc_q + B-imm; else pc_q + 4.
- PC arithmetic is modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0. Low two bits of pc_q are always 0.
- IF/ID update, priority: reset or redirect_i or flush_i -> bubble (instr=NOP_INSTR, valid=0, pred_taken=0, pc=0); stall_i -> hold; else load {imem_rdata, pc_q, valid=1, pred}.
- flush_i with stall_i: IF/ID bubbles, PC holds. redirect_i implies flush; flush_i alone does not change PC.
- fetch_count increments by 1 on each edge where IF/ID loads valid=1; wraps at 2^32; cleared on reset.
- Reset values: pc_q=RESET_PC, imem_addr=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=4, ifid_valid=0, ifid_pred_taken=0, fetch_count=0.

## Timing
- imem_addr is pc_q directly (no combinational path from any input).
- Fetch latency: instruction at address A appears on ifid_* one edge after imem_addr=A with stall_i low.
- Throughput: one instruction per cycle when not stalled.
- Redirect asserted in cycle N: imem_addr=target in N+1, ifid_valid=0 in N+1, target instruction valid in N+2.
- Stall is level-sensitive; each stalled cycle holds all state, including fetch_count.
- rst_n low mid-stream overrides stall/redirect in that cycle; first valid instruction appears on the first edge with rst_n high.

## Configuration
- FETCH_BTFN_EN defined: if imem_rdata[6:0]=7'b1100011 and imem_rdata[31]=1 (backward conditional branch), and no redirect/stall, next PC = pc_q + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}) and ifid_pred_taken=1 for that instruction. EX must redirect to pc+4 on mispredict.
- Not defined: next PC always pc_q + 4 when not redirected/stalled; ifid_pred_taken constant 0.

## Test plan
- Reset: rst_n low 3 cycles -> imem_addr=0, ifid_valid=0, ifid_instr=0x00000013, fetch_count=0; release -> after first edge ifid_pc=0, ifid_valid=1, imem_addr=4.
- Sequential: 5 unstalled cycles -> imem_addr 0,4,8,12,16; ifid_pc_plus4 = ifid_pc+4; fetch_count=5.
- Stall: stall_i high 2 cycles while imem_addr=8 -> imem_addr stays 8, ifid_pc stays 4, fetch_count unchanged; release -> ifid_pc=8 next edge.
- Redirect: redirect_i with redirect_pc_i=0x2E and stall_i high -> next cycle imem_addr=0x2C, ifid_valid=0; following edge ifid_pc=0x2C valid.
- Flush only: flush_i at imem_addr=0x10 -> ifid_valid=0, ifid_instr=0x00000013, imem_addr=0x14.
- BTFN: 0xFE000CE3 (beq x0,x0,-8) fetched at 0x20 -> with FETCH_BTFN_EN imem_addr=0x18 and ifid_pred_taken=1; without it imem_addr=0x24, ifid_pred_taken=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: the instruction-memory port, the hazard/branch controls and
// the IF/ID register outputs of the fetch stage, bundled in one interface.
// The master modport is the fetch stage. The slave modport is its environment:
// instruction memory, hazard unit, EX stage and decode.
interface fetch_stage_if;

  // Instruction memory port
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  // Hazard and branch-resolution controls
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  // IF/ID pipeline register towards decode
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        ifid_pred_taken;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall_i,
    input  flush_i,
    input  redirect_i,
    input  redirect_pc_i,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_valid,
    output ifid_pred_taken,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall_i,
    output flush_i,
    output redirect_i,
    output redirect_pc_i,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_valid,
    input  ifid_pred_taken,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined RISC-V core.
// The stage owns the program counter and drives it straight onto imem_addr.
// It registers the word that memory returns into IF/ID, together with its PC,
// a valid flag and a prediction flag. It also counts the instructions that
// reach IF/ID as valid.
// Optional feature: define FETCH_BTFN_EN to enable static backward-taken
// prediction for conditional branches. In the default build the next PC is
// always the sequential one and ifid_pred_taken stays 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_stage_if.master   bus
);

`ifdef FETCH_BTFN_EN
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Sign-extended B-type immediate of a branch instruction.
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction
`endif

  // Architectural state
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;
  logic        r_ifid_pred_taken;
  logic [31:0] r_fetch_count;

  // Next-state values
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;
  logic        w_pred_taken;
  logic [31:0] w_pred_pc;
  logic        w_ifid_bubble;
  logic        w_ifid_load;
  logic [31:0] w_next_instr;
  logic [31:0] w_next_ifid_pc;
  logic [31:0] w_next_ifid_pc_plus4;
  logic        w_next_valid;
  logic        w_next_pred_taken;
  logic [31:0] w_next_count;

  // Static prediction: a backward conditional branch is predicted taken,
  // but only when the PC is actually free to advance this cycle.
  always_comb begin
    w_seq_pc     = r_pc + 32'd4;
    w_pred_taken = 1'b0;
    w_pred_pc    = w_seq_pc;
`ifdef FETCH_BTFN_EN
    if ((bus.imem_rdata[6:0] == OPC_BRANCH) && bus.imem_rdata[31] &&
        !bus.redirect_i && !bus.stall_i) begin
      w_pred_taken = 1'b1;
      w_pred_pc    = r_pc + b_imm(bus.imem_rdata);
    end else begin
      w_pred_taken = 1'b0;
      w_pred_pc    = w_seq_pc;
    end
`endif
  end

  // Next PC selection. A redirect wins over a stall. The redirect target is
  // word-aligned so that the low two bits of the PC are always zero.
  always_comb begin
    w_next_pc = w_seq_pc;
    if (bus.redirect_i) begin
      w_next_pc = {bus.redirect_pc_i[31:2], 2'b00};
    end else if (bus.stall_i) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_pc;
    end else begin
      w_next_pc = w_seq_pc;
    end
  end

  // IF/ID next value. A redirect implies a flush. A flush wins over a stall,
  // so a stalled cycle can still be turned into a bubble.
  always_comb begin
    w_ifid_bubble        = bus.redirect_i | bus.flush_i;
    w_ifid_load          = 1'b0;
    w_next_instr         = r_ifid_instr;
    w_next_ifid_pc       = r_ifid_pc;
    w_next_ifid_pc_plus4 = r_ifid_pc_plus4;
    w_next_valid         = r_ifid_valid;
    w_next_pred_taken    = r_ifid_pred_taken;
    if (w_ifid_bubble) begin
      w_next_instr         = NOP_INSTR;
      w_next_ifid_pc       = 32'h0000_0000;
      w_next_ifid_pc_plus4 = 32'h0000_0004;
      w_next_valid         = 1'b0;
      w_next_pred_taken    = 1'b0;
    end else if (bus.stall_i) begin
      w_ifid_load = 1'b0;
    end else begin
      w_ifid_load          = 1'b1;
      w_next_instr         = bus.imem_rdata;
      w_next_ifid_pc       = r_pc;
      w_next_ifid_pc_plus4 = w_seq_pc;
      w_next_valid         = 1'b1;
      w_next_pred_taken    = w_pred_taken;
    end
  end

  // Delivered-instruction counter. It advances only when a valid instruction
  // enters IF/ID and wraps naturally at 2^32.
  always_comb begin
    w_next_count = r_fetch_count;
    if (w_ifid_load) begin
      w_next_count = r_fetch_count + 32'd1;
    end else begin
      w_next_count = r_fetch_count;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc              <= RESET_PC;
      r_ifid_instr      <= NOP_INSTR;
      r_ifid_pc         <= 32'h0000_0000;
      r_ifid_pc_plus4   <= 32'h0000_0004;
      r_ifid_valid      <= 1'b0;
      r_ifid_pred_taken <= 1'b0;
      r_fetch_count     <= 32'h0000_0000;
    end else begin
      r_pc              <= w_next_pc;
      r_ifid_instr      <= w_next_instr;
      r_ifid_pc         <= w_next_ifid_pc;
      r_ifid_pc_plus4   <= w_next_ifid_pc_plus4;
      r_ifid_valid      <= w_next_valid;
      r_ifid_pred_taken <= w_next_pred_taken;
      r_fetch_count     <= w_next_count;
    end
  end

  // Every output comes straight from a register, so imem_addr has no
  // combinational path from any input.
  assign bus.imem_addr       = r_pc;
  assign bus.ifid_instr      = r_ifid_instr;
  assign bus.ifid_pc         = r_ifid_pc;
  assign bus.ifid_pc_plus4   = r_ifid_pc_plus4;
  assign bus.ifid_valid      = r_ifid_valid;
  assign bus.ifid_pred_taken = r_ifid_pred_taken;
  assign bus.fetch_count     = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized control traffic.
// The outputs are compared against a transaction-level model of the fetch
// rules. Instruction memory is a small array that is read combinationally.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] rpc;
  logic [31:0] mem [0:255];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_valid;
  logic        m_pred;
  logic [31:0] m_cnt;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.stall_i       = stall;
  assign bus.flush_i       = flush;
  assign bus.redirect_i    = redirect;
  assign bus.redirect_pc_i = rpc;
  always_comb bus.imem_rdata = mem[bus.imem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock according to the fetch rules.
  task automatic model_step();
    logic [31:0] w;
    logic [31:0] npc;
    logic        pred;
    int          off;
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h13; m_ipc = 32'h0;
      m_valid = 1'b0; m_pred = 1'b0; m_cnt = 32'h0;
    end else begin
      w    = mem[m_pc[9:2]];
      pred = 1'b0;
      off  = 0;
`ifdef FETCH_BTFN_EN
      if (w[6:0] == 7'h63 && w[31] && !redirect && !stall) pred = 1'b1;
`endif
      // B-immediate as a signed byte offset
      off = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      if (redirect)  npc = rpc & 32'hFFFF_FFFC;
      else if (stall) npc = m_pc;
      else if (pred)  npc = m_pc + 32'(off);
      else            npc = m_pc + 32'd4;
      if (redirect || flush) begin
        m_instr = 32'h13; m_ipc = 32'h0; m_valid = 1'b0; m_pred = 1'b0;
      end else if (!stall) begin
        m_instr = w; m_ipc = m_pc; m_valid = 1'b1; m_pred = pred;
        m_cnt = m_cnt + 32'd1;
      end
      m_pc = npc;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("imem_addr", bus.imem_addr, m_pc);
    check("ifid_instr", bus.ifid_instr, m_instr);
    check("ifid_pc", bus.ifid_pc, m_ipc);
    check("ifid_pc_plus4", bus.ifid_pc_plus4, m_ipc + 32'd4);
    check("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
    check("ifid_pred", {31'b0, bus.ifid_pred_taken}, {31'b0, m_pred});
    check("fetch_count", bus.fetch_count, m_cnt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; rpc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[8] = 32'hFE00_0CE3;  // beq x0,x0,-8 at 0x20

    // Reset held for three cycles
    repeat (3) cycle();
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
    check("rst_instr", bus.ifid_instr, 32'h0000_0013);
    check("rst_count", bus.fetch_count, 32'h0);
    rst_n = 1'b1;
    cycle();
    check("rel_pc", bus.ifid_pc, 32'h0);
    check("rel_valid", {31'b0, bus.ifid_valid}, 32'h1);
    check("rel_addr", bus.imem_addr, 32'h4);
    repeat (4) cycle();
    check("seq_count", bus.fetch_count, 32'd5);
    check("seq_addr", bus.imem_addr, 32'h14);

    // Stall for two cycles while imem_addr is 8
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    repeat (2) cycle();
    stall = 1'b1;
    repeat (2) cycle();
    check("stall_addr", bus.imem_addr, 32'h8);
    check("stall_ifpc", bus.ifid_pc, 32'h4);
    check("stall_count", bus.fetch_count, 32'd2);
    stall = 1'b0;
    cycle();
    check("unstall_ifpc", bus.ifid_pc, 32'h8);

    // Redirect to an unaligned target while stalled
    redirect = 1'b1; rpc = 32'h2E; stall = 1'b1;
    cycle();
    check("redir_addr", bus.imem_addr, 32'h2C);
    check("redir_valid", {31'b0, bus.ifid_valid}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    cycle();
    check("redir_ifpc", bus.ifid_pc, 32'h2C);
    check("redir_valid2", {31'b0, bus.ifid_valid}, 32'h1);

    // Flush alone at address 0x10
    redirect = 1'b1; rpc = 32'h10; cycle(); redirect = 1'b0;
    flush = 1'b1;
    cycle();
    check("flush_valid", {31'b0, bus.ifid_valid}, 32'h0);
    check("flush_instr", bus.ifid_instr, 32'h0000_0013);
    check("flush_addr", bus.imem_addr, 32'h14);
    flush = 1'b0;

    // Backward branch fetched at 0x20
    redirect = 1'b1; rpc = 32'h20; cycle(); redirect = 1'b0;
    cycle();
    check("btfn_ifpc", bus.ifid_pc, 32'h20);
    check("btfn_instr", bus.ifid_instr, 32'hFE00_0CE3);
`ifdef FETCH_BTFN_EN
    check("btfn_addr", bus.imem_addr, 32'h18);
    check("btfn_pred", {31'b0, bus.ifid_pred_taken}, 32'h1);
`else
    check("btfn_addr", bus.imem_addr, 32'h24);
    check("btfn_pred", {31'b0, bus.ifid_pred_taken}, 32'h0);
`endif

    // Randomized traffic: mixed memory contents and random control inputs
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3) == 0)
        mem[i] = {$urandom_range(1) == 1, 24'($urandom), 7'h63};
      else
        mem[i] = $urandom;
    end
    mem[255] = 32'h0000_0013;
    for (int c = 0; c < 800; c++) begin
      rst_n    = ($urandom_range(63) != 0);
      stall    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(9) == 0);
      redirect = ($urandom_range(11) == 0);
      rpc      = (c % 97 == 5) ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
